// File: rtl/lfclk_pkg.sv
// Shared types and constants for the low-frequency clock controller.
// Holds the FSM state encoding, width defaults and the divider clamp helper.
package lfclk_pkg;

    localparam int DIV_W_DEF        = 16;
    localparam int FRAC_W_DEF       = 8;
    localparam int DIV_DEFAULT_DEF  = 256;
    localparam int FRAC_DEFAULT_DEF = 0;
    localparam int DIV_MIN          = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } lfclk_state_e;

    // A period shorter than two cycles cannot carry both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        logic [31:0] res;
        if (div < 32'(DIV_MIN)) begin
            res = 32'(DIV_MIN);
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/lfclk_phase_gen.sv
// Phase counter for one lf_clk period: latches the period length (integer
// divide plus fractional carry) at each period start and drives lf_clk.
module lfclk_phase_gen
    import lfclk_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk8388,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              adv_i,
    input  logic              acc_clr_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              lf_clk_o,
    output logic              last_o
);

    logic [DIV_W:0]  cnt_q, cnt_d;
    logic [DIV_W:0]  period_q, period_d;
    logic [DIV_W:0]  high_q, high_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic            clk_q, clk_d;
    logic [FRAC_W:0] sum_s;
    logic [DIV_W:0]  p_new_s;
    logic [DIV_W:0]  cnt_inc_s;

    // Next-period length and next phase state; period geometry only changes on start_i.
    always_comb begin
        sum_s     = {1'b0, (acc_clr_i ? {FRAC_W{1'b0}} : acc_q)} + {1'b0, frac_i};
        p_new_s   = {1'b0, div_i} + {{DIV_W{1'b0}}, sum_s[FRAC_W]};
        cnt_inc_s = cnt_q + {{DIV_W{1'b0}}, 1'b1};
        cnt_d     = cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        acc_d     = acc_q;
        clk_d     = clk_q;
        if (start_i) begin
            cnt_d    = {(DIV_W+1){1'b0}};
            period_d = p_new_s;
            high_d   = {1'b0, p_new_s[DIV_W:1]};
            acc_d    = sum_s[FRAC_W-1:0];
            clk_d    = 1'b1;
        end else if (adv_i) begin
            cnt_d = cnt_inc_s;
            clk_d = (cnt_inc_s < high_q);
        end else begin
            cnt_d = {(DIV_W+1){1'b0}};
            clk_d = 1'b0;
            if (acc_clr_i) begin
                acc_d = {FRAC_W{1'b0}};
            end else begin
                acc_d = acc_q;
            end
        end
    end

    // Phase state registers.
    always_ff @(posedge clk8388 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= {(DIV_W+1){1'b0}};
            period_q <= {(DIV_W+1){1'b0}};
            high_q   <= {(DIV_W+1){1'b0}};
            acc_q    <= {FRAC_W{1'b0}};
            clk_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            acc_q    <= acc_d;
            clk_q    <= clk_d;
        end
    end

    assign lf_clk_o = clk_q;
    assign last_o   = (cnt_q == (period_q - {{DIV_W{1'b0}}, 1'b1}));

endmodule

// File: rtl/lfclk_ctrl.sv
// Low-frequency clock controller: run/stop FSM, shadowed period config with
// boundary-aligned activation, tick counter and sticky compare alarm.
module lfclk_ctrl
    import lfclk_pkg::*;
#(
    parameter int DIV_W        = DIV_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF,
    parameter int DIV_DEFAULT  = DIV_DEFAULT_DEF,
    parameter int FRAC_DEFAULT = FRAC_DEFAULT_DEF
) (
    input  logic              clk8388,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [31:0]       cmp_val,
    input  logic              irq_clr,
    output logic              lf_clk,
    output logic              lf_tick,
    output logic              busy,
    output logic [31:0]       tick_cnt,
    output logic              irq
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_RUN      = ST_RUN;
    localparam logic [1:0] S_STOPPING = ST_STOPPING;

    logic [1:0]        state_q, state_d;
    logic              pending_q, pending_d;
    logic [DIV_W-1:0]  sh_div_q, sh_div_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic [DIV_W-1:0]  act_div_q, act_div_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic              lf_tick_q, busy_q, irq_q, irq_d;
    logic [31:0]       tick_cnt_q, tick_cnt_d;

    logic              start_s, adv_s, last_s, apply_s, accept_s;
    logic [DIV_W-1:0]  div_eff_s, div_clamp_s;
    logic [FRAC_W-1:0] frac_eff_s;
    logic [31:0]       tick_inc_s;

    assign div_clamp_s = DIV_W'(clamp_div(32'(cfg_div)));

    // A stop request only takes effect at the end of the running period.
    always_comb begin
        start_s = 1'b0;
        adv_s   = 1'b0;
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    start_s = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN, S_STOPPING: begin
                if (last_s) begin
                    if (en) begin
                        start_s = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    adv_s   = 1'b1;
                    state_d = en ? S_RUN : S_STOPPING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Config shadow: accepted when not pending, promoted at a period start or while idle.
    always_comb begin
        accept_s   = cfg_valid && !pending_q;
        apply_s    = pending_q && ((state_q == S_IDLE) || start_s);
        pending_d  = pending_q;
        sh_div_d   = sh_div_q;
        sh_frac_d  = sh_frac_q;
        act_div_d  = act_div_q;
        act_frac_d = act_frac_q;
        if (accept_s) begin
            pending_d = 1'b1;
            sh_div_d  = div_clamp_s;
            sh_frac_d = cfg_frac;
        end else if (apply_s) begin
            pending_d  = 1'b0;
            act_div_d  = sh_div_q;
            act_frac_d = sh_frac_q;
        end else begin
            pending_d = pending_q;
        end
        div_eff_s  = apply_s ? sh_div_q : act_div_q;
        frac_eff_s = apply_s ? sh_frac_q : act_frac_q;
    end

    // Tick counter and alarm; a new match outranks a simultaneous clear.
    always_comb begin
        tick_inc_s = tick_cnt_q + 32'd1;
        if (start_s) begin
            tick_cnt_d = tick_inc_s;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
        irq_d = (start_s && (tick_inc_s == cmp_val)) || (irq_q && !irq_clr);
    end

    // Control, config and status registers.
    always_ff @(posedge clk8388 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            sh_div_q   <= DIV_W'(DIV_DEFAULT);
            sh_frac_q  <= FRAC_W'(FRAC_DEFAULT);
            act_div_q  <= DIV_W'(DIV_DEFAULT);
            act_frac_q <= FRAC_W'(FRAC_DEFAULT);
            lf_tick_q  <= 1'b0;
            busy_q     <= 1'b0;
            tick_cnt_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            sh_div_q   <= sh_div_d;
            sh_frac_q  <= sh_frac_d;
            act_div_q  <= act_div_d;
            act_frac_q <= act_frac_d;
            lf_tick_q  <= start_s;
            busy_q     <= (state_d != S_IDLE);
            tick_cnt_q <= tick_cnt_d;
            irq_q      <= irq_d;
        end
    end

    lfclk_phase_gen #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_phase (
        .clk8388   (clk8388),
        .rst_n     (rst_n),
        .start_i   (start_s),
        .adv_i     (adv_s),
        .acc_clr_i (apply_s),
        .div_i     (div_eff_s),
        .frac_i    (frac_eff_s),
        .lf_clk_o  (lf_clk),
        .last_o    (last_s)
    );

    assign cfg_ready = !pending_q;
    assign lf_tick   = lf_tick_q;
    assign busy      = busy_q;
    assign tick_cnt  = tick_cnt_q;
    assign irq       = irq_q;

endmodule
